// File: rtl/host_bus_cycle_seq.sv
// Turns one requester beat into a single 6502-style host bus cycle timed against synchronised PHI0.
// Optional HOST_RDY_EN: reads are stretched while host RDY is low at the PHI2 fall.
module host_bus_cycle_seq #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [15:0] IDLE_ADDR    = 16'hFFFF,
    parameter int unsigned TIMEOUT_BITS = 8
) (
    input  logic        hsclk,
    input  logic        rst,
    input  logic        bbc_phi0,
    input  logic        bbc_rdy,
    input  logic        req,
    input  logic        req_rnw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [15:0] bbc_addr,
    output logic        bbc_rnw,
    output logic [7:0]  bbc_dout,
    output logic        bbc_doe,
    input  logic [7:0]  bbc_din,
    output logic        phi0_lost
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_P1, S_PH1, S_PH2, S_HOLD} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  phi_sync_q, phi_sync_d;
    logic                    p0_dly_q, p0_dly_d;
    logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
    logic                    lost_q, lost_d;
    logic [15:0]             lat_addr_q, lat_addr_d;
    logic                    lat_rnw_q, lat_rnw_d;
    logic [7:0]              lat_wdata_q, lat_wdata_d;
    logic [7:0]              samp_q, samp_d;
    logic [7:0]              rdata_q, rdata_d;
    logic                    ack_q, ack_d;
    logic                    busy_q, busy_d;
    logic [15:0]             addr_q, addr_d;
    logic                    rnw_q, rnw_d;
    logic [7:0]              dout_q, dout_d;
    logic                    doe_q, doe_d;
    logic                    p0, fall, rise, stretch;

    assign p0   = phi_sync_q[SYNC_STAGES-1];
    assign fall = p0_dly_q & ~p0;
    assign rise = ~p0_dly_q & p0;

`ifdef HOST_RDY_EN
    logic [SYNC_STAGES-1:0] rdy_sync_q;

    // RDY synchroniser; only reads honour it, writes complete regardless
    always_ff @(posedge hsclk or posedge rst) begin
        if (rst) rdy_sync_q <= '0;
        else     rdy_sync_q <= {rdy_sync_q[SYNC_STAGES-2:0], bbc_rdy};
    end
    assign stretch = lat_rnw_q & ~rdy_sync_q[SYNC_STAGES-1];
`else
    logic rdy_unused;
    assign rdy_unused = bbc_rdy;
    assign stretch    = 1'b0;
`endif

    always_ff @(posedge hsclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phi_sync_q  <= '0;
            p0_dly_q    <= 1'b0;
            wd_q        <= '0;
            lost_q      <= 1'b0;
            lat_addr_q  <= '0;
            lat_rnw_q   <= 1'b1;
            lat_wdata_q <= '0;
            samp_q      <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            addr_q      <= IDLE_ADDR;
            rnw_q       <= 1'b1;
            dout_q      <= '0;
            doe_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phi_sync_q  <= phi_sync_d;
            p0_dly_q    <= p0_dly_d;
            wd_q        <= wd_d;
            lost_q      <= lost_d;
            lat_addr_q  <= lat_addr_d;
            lat_rnw_q   <= lat_rnw_d;
            lat_wdata_q <= lat_wdata_d;
            samp_q      <= samp_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            rnw_q       <= rnw_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phi_sync_d  = {phi_sync_q[SYNC_STAGES-2:0], bbc_phi0};
        p0_dly_d    = p0;
        wd_d        = wd_q;
        lat_addr_d  = lat_addr_q;
        lat_rnw_d   = lat_rnw_q;
        lat_wdata_d = lat_wdata_q;
        samp_d      = samp_q;
        rdata_d     = rdata_q;
        ack_d       = 1'b0;
        busy_d      = busy_q;
        addr_d      = addr_q;
        rnw_d       = rnw_q;
        dout_d      = dout_q;
        doe_d       = doe_q;

        // Watchdog: any PHI0 edge restarts it, otherwise count up and saturate
        if (fall | rise)    wd_d = '0;
        else if (~&wd_q)    wd_d = wd_q + TIMEOUT_BITS'(1);
        lost_d = &wd_d;

        case (state_q)
            S_IDLE: begin
                addr_d = IDLE_ADDR;
                rnw_d  = 1'b1;
                doe_d  = 1'b0;
                if (req) begin
                    lat_addr_d  = req_addr;
                    lat_rnw_d   = req_rnw;
                    lat_wdata_d = req_wdata;
                    busy_d      = 1'b1;
                    state_d     = S_WAIT_P1;
                end
            end
            // Cycles only begin at a PHI1 boundary
            S_WAIT_P1: begin
                if (fall) begin
                    addr_d  = lat_addr_q;
                    rnw_d   = lat_rnw_q;
                    state_d = S_PH1;
                end
            end
            S_PH1: begin
                if (rise) begin
                    state_d = S_PH2;
                    if (!lat_rnw_q) begin
                        doe_d  = 1'b1;
                        dout_d = lat_wdata_q;
                    end
                end
            end
            S_PH2: begin
                if (p0) samp_d = bbc_din;
                if (fall) begin
                    if (stretch) begin
                        state_d = S_PH1;
                    end else begin
                        if (lat_rnw_q) rdata_d = samp_q;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                ack_d   = 1'b1;
                busy_d  = 1'b0;
                addr_d  = IDLE_ADDR;
                rnw_d   = 1'b1;
                doe_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign bbc_addr  = addr_q;
    assign bbc_rnw   = rnw_q;
    assign bbc_dout  = dout_q;
    assign bbc_doe   = doe_q;
    assign phi0_lost = lost_q;

endmodule

// File: tb/tb_host_bus_cycle_seq.sv
// Directed bench for host_bus_cycle_seq: table of host transfers plus reset and watchdog sequences.
module tb_host_bus_cycle_seq;

    localparam int unsigned SYNC = 2;

    logic        hsclk = 1'b0;
    logic        rst, bbc_phi0, bbc_rdy, req, req_rnw;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata, bbc_din;
    logic        ack, busy, bbc_rnw, bbc_doe, phi0_lost;
    logic [7:0]  rdata, bbc_dout;
    logic [15:0] bbc_addr;

    int checks   = 0;
    int failures = 0;
    int hi_len   = 8;
    int lo_len   = 8;
    bit phi_run  = 1'b1;

    host_bus_cycle_seq #(.SYNC_STAGES(SYNC), .IDLE_ADDR(16'hFFFF), .TIMEOUT_BITS(8)) dut (
        .hsclk(hsclk), .rst(rst), .bbc_phi0(bbc_phi0), .bbc_rdy(bbc_rdy),
        .req(req), .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack), .rdata(rdata), .busy(busy), .bbc_addr(bbc_addr), .bbc_rnw(bbc_rnw),
        .bbc_dout(bbc_dout), .bbc_doe(bbc_doe), .bbc_din(bbc_din), .phi0_lost(phi0_lost)
    );

    always #5 hsclk = ~hsclk;

    // Host PHI0: 16 hsclk per cycle by default, changes just after a rising edge
    initial begin
        int cnt;
        cnt = 0;
        bbc_phi0 = 1'b0;
        forever begin
            @(posedge hsclk);
            #2;
            if (phi_run) begin
                cnt++;
                if (cnt >= (bbc_phi0 ? hi_len : lo_len)) begin
                    bbc_phi0 = ~bbc_phi0;
                    cnt = 0;
                end
            end
        end
    end

    typedef struct {
        logic        rnw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        logic [7:0]  din_late;
        int          hi_len;
        int          rdy_falls;
        int          nfalls;
        logic [7:0]  exp_rdata;
    } xfer_t;

    xfer_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input xfer_t r);
        int  n, falls, since, hi_cnt;
        logic prev, prev_doe;
        bit  got_ack, bad, saw_doe;
        @(negedge hsclk);
        hi_len    = r.hi_len;
        bbc_din   = r.din;
        bbc_rdy   = (r.rdy_falls == 0);
        req       = 1'b1;
        req_rnw   = r.rnw;
        req_addr  = r.addr;
        req_wdata = r.wdata;
        n = 0;
        while (bbc_addr !== r.addr && n < 400) begin
            @(negedge hsclk);
            n++;
        end
        chk("addr_start", 32'(bbc_addr), 32'(r.addr));
        chk("rnw_start", 32'(bbc_rnw), 32'(r.rnw));
        chk("busy_during", 32'(busy), 32'(1));
        falls = 0; since = 0; hi_cnt = 0; prev = bbc_phi0; prev_doe = bbc_doe;
        got_ack = 1'b0; bad = 1'b0; saw_doe = 1'b0;
        for (int i = 0; i < 2000 && !got_ack; i++) begin
            @(negedge hsclk);
            if (prev && !bbc_phi0) begin
                falls++;
                since = 0;
            end else begin
                since++;
            end
            prev   = bbc_phi0;
            hi_cnt = bbc_phi0 ? hi_cnt + 1 : 0;
            if (hi_cnt == 12) bbc_din = r.din_late;
            if (!bbc_rdy && falls == r.rdy_falls && since == 8) bbc_rdy = 1'b1;
            if (ack) begin
                got_ack = 1'b1;
            end else begin
                if (bbc_addr !== r.addr || bbc_rnw !== r.rnw) bad = 1'b1;
                if (bbc_doe && bbc_dout == r.wdata) saw_doe = 1'b1;
                prev_doe = bbc_doe;
            end
        end
        req = 1'b0;
        chk("ack_seen", 32'(got_ack), 32'(1));
        chk("falls_to_ack", 32'(falls), 32'(r.nfalls));
        chk("ack_latency", 32'(since), 32'(SYNC + 2));
        chk("addr_rnw_held", 32'(bad), 32'(0));
        chk("doe_before_ack", 32'(prev_doe), 32'(!r.rnw));
        if (!r.rnw) chk("doe_dout_seen", 32'(saw_doe), 32'(1));
        chk("doe_at_ack", 32'(bbc_doe), 32'(0));
        chk("busy_at_ack", 32'(busy), 32'(0));
        chk("rdata", 32'(rdata), 32'(r.exp_rdata));
        for (int i = 0; i < 3; i++) begin
            @(negedge hsclk);
            chk("ack_single", 32'(ack), 32'(0));
        end
        chk("idle_addr", 32'(bbc_addr), 32'hFFFF);
        chk("idle_rnw", 32'(bbc_rnw), 32'(1));
        chk("idle_busy", 32'(busy), 32'(0));
        bbc_rdy = 1'b1;
    endtask

    initial begin
        xfer_t rr;
        bit    seen;
        int    n;
        logic  v;
        tbl[0] = '{1'b1, 16'hFE40, 8'h00, 8'hA5, 8'hA5, 8,  0, 1, 8'hA5};
        tbl[1] = '{1'b0, 16'h3000, 8'h5C, 8'h00, 8'h00, 8,  0, 1, 8'hA5};
        tbl[2] = '{1'b1, 16'h1234, 8'h00, 8'h3C, 8'h3C, 8,  0, 1, 8'h3C};
        tbl[3] = '{1'b1, 16'h8000, 8'h00, 8'h11, 8'h77, 24, 0, 1, 8'h77};
`ifdef HOST_RDY_EN
        tbl[4] = '{1'b1, 16'hFE60, 8'h00, 8'hC3, 8'hC3, 8,  2, 3, 8'hC3};
`else
        tbl[4] = '{1'b1, 16'hFE60, 8'h00, 8'hC3, 8'hC3, 8,  2, 1, 8'hC3};
`endif
        tbl[5] = '{1'b0, 16'h4000, 8'h9E, 8'h00, 8'h00, 8,  2, 1, 8'hC3};
        tbl[6] = '{1'b1, 16'h0000, 8'h00, 8'h5A, 8'h5A, 8,  0, 1, 8'h5A};

        rst = 1'b1; bbc_rdy = 1'b1; req = 1'b0; req_rnw = 1'b1;
        req_addr = 16'h0000; req_wdata = 8'h00; bbc_din = 8'h00;
        repeat (3) @(negedge hsclk);
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rdata", 32'(rdata), 32'h00);
        chk("rst_addr", 32'(bbc_addr), 32'hFFFF);
        chk("rst_rnw", 32'(bbc_rnw), 32'(1));
        chk("rst_doe", 32'(bbc_doe), 32'(0));
        chk("rst_dout", 32'(bbc_dout), 32'h00);
        chk("rst_lost", 32'(phi0_lost), 32'(0));
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_xfer(tbl[i]);

        // Reset during the data phase of a write
        @(negedge hsclk);
        hi_len = 8; req = 1'b1; req_rnw = 1'b0; req_addr = 16'h5000; req_wdata = 8'hAA;
        n = 0;
        while (!bbc_doe && n < 400) begin
            @(negedge hsclk);
            n++;
        end
        chk("mid_write_doe", 32'(bbc_doe), 32'(1));
        @(negedge hsclk);
        #1 rst = 1'b1;
        #1;
        chk("async_doe", 32'(bbc_doe), 32'(0));
        chk("async_busy", 32'(busy), 32'(0));
        chk("async_addr", 32'(bbc_addr), 32'hFFFF);
        req = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge hsclk);
            if (ack) seen = 1'b1;
        end
        chk("no_ack_on_rst", 32'(seen), 32'(0));
        rst = 1'b0;
        rr = '{1'b1, 16'hFE42, 8'h00, 8'h6B, 8'h6B, 8, 0, 1, 8'h6B};
        run_xfer(rr);

        // PHI0 stops with a read pending, then resumes
        @(negedge hsclk);
        phi_run = 1'b0;
        bbc_din = 8'hE7; req = 1'b1; req_rnw = 1'b1; req_addr = 16'hFC00;
        seen = 1'b0;
        repeat (200) begin
            @(negedge hsclk);
            if (ack) seen = 1'b1;
        end
        chk("wd_not_yet", 32'(phi0_lost), 32'(0));
        repeat (100) begin
            @(negedge hsclk);
            if (ack) seen = 1'b1;
        end
        chk("wd_lost", 32'(phi0_lost), 32'(1));
        chk("wd_busy", 32'(busy), 32'(1));
        chk("wd_no_ack", 32'(seen), 32'(0));
        v = bbc_phi0;
        phi_run = 1'b1;
        n = 0;
        while (bbc_phi0 === v && n < 100) begin
            @(negedge hsclk);
            n++;
        end
        repeat (4) @(negedge hsclk);
        chk("wd_cleared", 32'(phi0_lost), 32'(0));
        n = 0;
        while (!ack && n < 400) begin
            @(negedge hsclk);
            n++;
        end
        req = 1'b0;
        chk("wd_ack", 32'(ack), 32'(1));
        chk("wd_rdata", 32'(rdata), 32'hE7);
        repeat (4) @(negedge hsclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/host_bus_cycle_seq.md
Name: host_bus_cycle_seq

Overview:
- Lives in the CPLD and runs on the fast oscillator clock `hsclk`.
- Turns a single-beat request from the fast 65816 side into one 6502-compatible bus cycle on the host CPU socket. The cycle is timed against the host's PHI0, sampled inside the block.
- It is the initiator end of the host socket protocol: it drives address, RnW and write data, and samples read data on the PHI2 falling edge.
- The host's own clock stretching (1MHz areas) is followed automatically by tracking PHI0 edges.

Parameters:
- SYNC_STAGES, 2, number of flops on the PHI0 (and RDY) synchroniser; minimum 2.
- IDLE_ADDR, 16'hFFFF, address presented on host idle cycles. A ROM location, so idle reads have no side effects.
- TIMEOUT_BITS, 8, width of the PHI0-activity watchdog counter.

Ports:
- hsclk  in  1  block clock, high-speed oscillator.
- rst  in  1  asynchronous, active-high reset.
- bbc_phi0  in  1  host PHI0, asynchronous to hsclk.
- bbc_rdy  in  1  host RDY, asynchronous, active high.
- req  in  1  transfer request, level; held by the requester until ack.
- req_rnw  in  1  1=read, 0=write.
- req_addr  in  16  host address.
- req_wdata  in  8  write data.
- ack  out  1  one-cycle pulse: transfer complete.
- rdata  out  8  read data, valid from ack onward until the next ack.
- busy  out  1  high from request acceptance until ack.
- bbc_addr  out  16  address to host socket.
- bbc_rnw  out  1  RnW to host socket.
- bbc_dout  out  8  write data to host data bus.
- bbc_doe  out  1  host data bus output enable.
- bbc_din  in  8  host data bus input.
- phi0_lost  out  1  PHI0 watchdog expired.

Behaviour:
- Clock and reset:
  - Single clock `hsclk`. `rst` is asynchronous and active high.
  - Reset values: ack=0, busy=0, rdata=8'h00, bbc_addr=IDLE_ADDR, bbc_rnw=1, bbc_doe=0, bbc_dout=8'h00, phi0_lost=0, state=IDLE, synchroniser flops=0.
- Synchronisation and edges:
  - bbc_phi0 and bbc_rdy each pass through SYNC_STAGES flops.
  - `p0` is the synchronised PHI0 and `p0_d` is p0 delayed by one cycle.
  - fall = p0_d & ~p0; rise = ~p0_d & p0.
  - Edge latency from the pin is SYNC_STAGES+1 hsclk cycles.
- State machine:
  - IDLE:
    - Outputs are bbc_addr=IDLE_ADDR, bbc_rnw=1, bbc_doe=0.
    - If req=1, latch req_addr, req_rnw and req_wdata, set busy=1, and go to WAIT_P1.
  - WAIT_P1: on fall, drive bbc_addr=latched addr and bbc_rnw=latched rnw, then go to PH1. This means a cycle always starts at a PHI1 boundary; a request is never inserted mid-cycle.
  - PH1: on rise, go to PH2. For a write, assert bbc_doe=1 and bbc_dout=wdata in the same cycle.
  - PH2:
    - Every hsclk with p0=1, register bbc_din into `samp`.
    - On fall:
      - If the stretch condition holds (see below), stay in PH1 with the address unchanged.
      - Otherwise rdata<=samp for reads (rdata unchanged for writes), and go to HOLD.
  - HOLD:
    - Runs for one hsclk with the address, RnW and doe still held, to meet host hold time.
    - Then ack=1 for exactly one cycle, busy=0, and go to IDLE. Outputs revert to idle values in that same cycle.
- Request handshake:
  - req is sampled only in IDLE.
  - If req is still high in the cycle after ack, a new transaction starts; back-to-back transfers are allowed.
  - Changes to req_* while busy are ignored.
- Watchdog:
  - The counter clears on any rise or fall and otherwise increments.
  - When it reaches all-ones it saturates and phi0_lost=1.
  - The next edge clears phi0_lost.
  - The state machine does not abort; it keeps waiting.
- Reset mid-operation: all state returns to the reset values immediately, no ack is issued, and bbc_doe drops asynchronously.
- PHI0 stuck high at request: WAIT_P1 waits indefinitely for fall.

Optional Feature:
- HOST_RDY_EN defined:
  - Stretch condition = read & ~rdy_sync at the PHI2 fall. The cycle repeats (PH1→PH2) until RDY is high at a fall.
  - Writes ignore RDY, as on an NMOS 6502.
- Undefined: bbc_rdy is unused and every cycle completes at its first PHI2 fall.

Test Plan:
- Read: PHI0 = 2MHz square with a 32MHz hsclk; req read addr 16'hFE40, bbc_din=8'hA5 during PH2 → bbc_addr=FE40 from the first fall after req; ack pulses once SYNC_STAGES+2 cycles after the next fall; rdata=8'hA5; busy low after ack.
- Write: req write addr 16'h3000 data 8'h5C → bbc_doe high from rise to one cycle past fall; bbc_dout=5C; bbc_rnw=0 throughout; then idle, with addr=FFFF and rnw=1.
- Stretched cycle: the host holds PHI0 high 3× longer (1MHz area) → the cycle spans exactly one stretched PH2; rdata captures the bbc_din value present before the late fall.
- HOST_RDY_EN: read with bbc_rdy low across 2 PHI2 falls → bbc_addr held for 3 host cycles; ack only after the third fall. The same stimulus on a write → ack after the first fall.
- Reset mid-write: assert rst while in PH2 with doe=1 → doe=0 and busy=0 with no clock needed; no ack. After release, a new read completes normally.
- Watchdog: stop PHI0 for 300 hsclk → phi0_lost=1 after 255 cycles; restarting PHI0 clears it on the first edge and the pending transfer completes.
